// File: rtl/pipe_mips_param.sv
// Five-stage in-order MIPS-like core: IF/ID/EX/MEM/WB with full forwarding,
// load-use interlock, branches resolved in EX, and HLT-driven freeze.
module pipe_mips_param #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic [4:0]                    dbg_reg_addr,
  output logic [XLEN-1:0]               dbg_reg_data,
  input  logic [$clog2(DMEM_DEPTH)-1:0] dbg_mem_addr,
  output logic [XLEN-1:0]               dbg_mem_data,
  output logic                          halted,
  output logic [31:0]                   retired
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_AND   = 6'b000010,
                         OP_OR   = 6'b000011, OP_SLT  = 6'b000100, OP_MUL   = 6'b000101,
                         OP_LW   = 6'b001000, OP_SW   = 6'b001001, OP_ADDI  = 6'b001010,
                         OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                         OP_BEQZ = 6'b001110;

  typedef enum logic [2:0] {K_RR, K_RM, K_LW, K_SW, K_BR, K_HLT} kind_t;

  typedef struct packed {
    logic           vld;
    logic [31:0]    ir;
    logic [IAW-1:0] npc;
  } ifid_t;

  typedef struct packed {
    logic            vld;
    kind_t           kind;
    logic [31:0]     ir;
    logic [IAW-1:0]  npc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
  } idex_t;

  typedef struct packed {
    logic            vld;
    kind_t           kind;
    logic            wr;
    logic [4:0]      dst;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] b;
  } exmem_t;

  typedef struct packed {
    logic            vld;
    kind_t           kind;
    logic            wr;
    logic [4:0]      dst;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] lmd;
  } memwb_t;

  // Unknown opcodes fall into K_HLT so garbage in imem stops the core.
  function automatic kind_t kind_of(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: kind_of = K_RR;
      OP_ADDI, OP_SUBI, OP_SLTI:                     kind_of = K_RM;
      OP_LW:                                         kind_of = K_LW;
      OP_SW:                                         kind_of = K_SW;
      OP_BNEQZ, OP_BEQZ:                             kind_of = K_BR;
      default:                                       kind_of = K_HLT;
    endcase
  endfunction

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] regs [32];

  logic [IAW-1:0] pc;
  logic           fetch_off;
  ifid_t          ifid;
  idex_t          idex;
  exmem_t         exmem;
  memwb_t         memwb;

  // ---------------- ID ----------------
  kind_t           id_kind;
  logic [4:0]      id_rs, id_rt;
  logic [XLEN-1:0] id_a, id_b, id_imm;
  logic            id_use_rs, id_use_rt, stall, id_hlt;
  logic [XLEN-1:0] wb_val;
  logic            wb_we;

  assign id_kind = kind_of(ifid.ir[31:26]);
  assign id_rs   = ifid.ir[25:21];
  assign id_rt   = ifid.ir[20:16];
  assign id_imm  = {{(XLEN-16){ifid.ir[15]}}, ifid.ir[15:0]};
  assign id_hlt  = ifid.vld && (id_kind == K_HLT);

  assign wb_val = (memwb.kind == K_LW) ? memwb.lmd : memwb.alu;
  assign wb_we  = memwb.vld && memwb.wr && !halted;

  // Same-cycle WB write is visible to the ID read.
  always_comb begin
    id_a = (id_rs == 5'd0) ? '0 : regs[id_rs];
    id_b = (id_rt == 5'd0) ? '0 : regs[id_rt];
    if (wb_we && memwb.dst == id_rs) id_a = wb_val;
    if (wb_we && memwb.dst == id_rt) id_b = wb_val;
  end

  assign id_use_rs = ifid.vld && (id_kind != K_HLT);
  assign id_use_rt = ifid.vld && (id_kind == K_RR || id_kind == K_SW);

  always_comb begin
    stall = 1'b0;
    if (idex.vld && idex.kind == K_LW && idex.ir[20:16] != 5'd0)
      stall = (id_use_rs && id_rs == idex.ir[20:16]) ||
              (id_use_rt && id_rt == idex.ir[20:16]);
  end

  // ---------------- EX ----------------
  logic [5:0]      ex_op;
  logic [4:0]      ex_rs, ex_rt, ex_dst;
  logic [XLEN-1:0] fa, fb, ex_res;
  logic            ex_wr, taken;
  logic [IAW-1:0]  target;

  assign ex_op = idex.ir[31:26];
  assign ex_rs = idex.ir[25:21];
  assign ex_rt = idex.ir[20:16];

  // wr already excludes R0 and bubbles, so a match implies a real producer.
  always_comb begin
    fa = idex.a;
    fb = idex.b;
    if (exmem.wr && exmem.dst == ex_rs)      fa = exmem.alu;
    else if (memwb.wr && memwb.dst == ex_rs) fa = wb_val;
    if (exmem.wr && exmem.dst == ex_rt)      fb = exmem.alu;
    else if (memwb.wr && memwb.dst == ex_rt) fb = wb_val;
  end

  always_comb begin
    ex_res = '0;
    case (ex_op)
      OP_ADD:                 ex_res = fa + fb;
      OP_SUB:                 ex_res = fa - fb;
      OP_AND:                 ex_res = fa & fb;
      OP_OR:                  ex_res = fa | fb;
      OP_SLT:                 ex_res = XLEN'($signed(fa) < $signed(fb));
      OP_MUL:                 ex_res = fa * fb;
      OP_ADDI, OP_LW, OP_SW:  ex_res = fa + idex.imm;
      OP_SUBI:                ex_res = fa - idex.imm;
      OP_SLTI:                ex_res = XLEN'($signed(fa) < $signed(idex.imm));
      default:                ex_res = '0;
    endcase
  end

  assign ex_dst = (idex.kind == K_RR) ? idex.ir[15:11] : ex_rt;
  assign ex_wr  = idex.vld && (idex.kind == K_RR || idex.kind == K_RM || idex.kind == K_LW) &&
                  (ex_dst != 5'd0);
  assign taken  = idex.vld && (idex.kind == K_BR) &&
                  ((ex_op == OP_BEQZ) ? (fa == '0) : (fa != '0));
  assign target = idex.npc + idex.imm[IAW-1:0];

  // ---------------- MEM ----------------
  logic [DAW-1:0] mem_addr;
  assign mem_addr = exmem.alu[DAW-1:0];

  // ---------------- state ----------------
  logic fetch_stop;
  assign fetch_stop = fetch_off || (id_hlt && !taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      fetch_off <= 1'b0;
      ifid      <= '0;
      idex      <= '0;
      exmem     <= '0;
      memwb     <= '0;
      halted    <= 1'b0;
      retired   <= '0;
    end else if (!halted) begin
      if (memwb.vld) retired <= retired + 32'd1;
      if (memwb.vld && memwb.kind == K_HLT) halted <= 1'b1;

      memwb <= '{vld: exmem.vld, kind: exmem.kind, wr: exmem.wr, dst: exmem.dst,
                 alu: exmem.alu, lmd: dmem[mem_addr]};
      exmem <= '{vld: idex.vld, kind: idex.kind, wr: ex_wr, dst: ex_dst,
                 alu: ex_res, b: fb};

      // Flush outranks the load-use stall.
      if (taken || stall) idex <= '0;
      else idex <= '{vld: ifid.vld, kind: id_kind, ir: ifid.ir, npc: ifid.npc,
                     a: id_a, b: id_b, imm: id_imm};

      if (taken) begin
        ifid <= '0;
        pc   <= target;
      end else if (!stall) begin
        if (fetch_stop) ifid <= '0;
        else begin
          ifid <= '{vld: 1'b1, ir: imem[pc], npc: pc + IAW'(1)};
          pc   <= pc + IAW'(1);
        end
      end

      if (id_hlt && !taken) fetch_off <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && !halted && exmem.vld && exmem.kind == K_SW) dmem[mem_addr] <= exmem.b;
  end

  always_ff @(posedge clk) begin
    if (!rst && wb_we) regs[memwb.dst] <= wb_val;
  end

  assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? '0 : regs[dbg_reg_addr];
  assign dbg_mem_data = dmem[dbg_mem_addr];

endmodule

// File: tb/tb_pipe_mips_param.sv
// Directed bench for pipe_mips_param: hand-assembled programs with
// hand-computed register, memory, retire-count and cycle-count expectations.
module tb_pipe_mips_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, prog_we;
  logic [9:0]  prog_addr, dbg_mem_addr;
  logic [31:0] prog_data;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] reg32, mem32, ret32, ret64;
  logic [63:0] reg64, mem64;
  logic        halt32, halt64;

  pipe_mips_param #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(reg32), .dbg_mem_addr(dbg_mem_addr),
    .dbg_mem_data(mem32), .halted(halt32), .retired(ret32));

  pipe_mips_param #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(reg64), .dbg_mem_addr(dbg_mem_addr),
    .dbg_mem_data(mem64), .halted(halt64), .retired(ret64));

  int n_cmp = 0, n_bad = 0;
  logic [31:0] prog [0:15];
  int plen, cyc;

  localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, SLT = 6'd4,
                         MUL = 6'd5, LW = 6'd8, SW = 6'd9, ADDI = 6'd10, SUBI = 6'd11,
                         SLTI = 6'd12, BNEQZ = 6'd13, BEQZ = 6'd14;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd, rs, rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction
  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt, rs,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic load_prog();
    rst = 1'b1; prog_we = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < plen; i++) begin
      prog_we = 1'b1; prog_addr = 10'(i); prog_data = prog[i];
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
  endtask

  task automatic run_prog();
    load_prog();
    rst = 1'b0; cyc = 0;
    while (halt32 !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic rreg(input logic [4:0] a);
    dbg_reg_addr = a; #1;
  endtask
  task automatic rmem(input logic [9:0] a);
    dbg_mem_addr = a; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; prog_we = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (halt32 !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halt32); end
    n_cmp++; if (ret32 !== 32'd0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", ret32); end
  endtask

  task automatic test_forwarding();
    prog[0] = ri(ADDI, 1, 0, 16'd10); prog[1] = ri(ADDI, 2, 0, 16'd20);
    prog[2] = rr(ADD, 3, 1, 2);       prog[3] = HLT; plen = 4;
    run_prog();
    rreg(3);
    n_cmp++; if (reg32 !== 32'd30) begin n_bad++; $display("FAIL fwd_r3: got %0d want 30", reg32); end
    n_cmp++; if (ret32 !== 32'd4) begin n_bad++; $display("FAIL fwd_retired: got %0d want 4", ret32); end
    n_cmp++; if (halt32 !== 1'b1 || cyc != 8) begin n_bad++; $display("FAIL fwd_cycles: got halted=%b cyc=%0d want 1/8", halt32, cyc); end
    // reset is asynchronous: state clears without a clock edge
    rst = 1'b1; #1;
    n_cmp++; if (halt32 !== 1'b0 || ret32 !== 32'd0) begin n_bad++; $display("FAIL async_reset: got halted=%b retired=%0d want 0/0", halt32, ret32); end
  endtask

  task automatic test_load_use();
    prog[0] = ri(ADDI, 1, 0, 16'd100); prog[1] = ri(SW, 1, 0, 16'd7);
    prog[2] = ri(LW, 2, 0, 16'd7);     prog[3] = rr(ADD, 3, 2, 2);
    prog[4] = HLT; plen = 5;
    run_prog();
    rmem(7);
    n_cmp++; if (mem32 !== 32'd100) begin n_bad++; $display("FAIL lu_mem7: got %0d want 100", mem32); end
    rreg(3);
    n_cmp++; if (reg32 !== 32'd200) begin n_bad++; $display("FAIL lu_r3: got %0d want 200", reg32); end
    n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL lu_cycles: got %0d want 10", cyc); end
    n_cmp++; if (ret32 !== 32'd5) begin n_bad++; $display("FAIL lu_retired: got %0d want 5", ret32); end
  endtask

  task automatic test_alu();
    prog[0] = ri(ADDI, 1, 0, 16'hFFFA); prog[1] = ri(ADDI, 2, 0, 16'd13);
    prog[2] = rr(SUB, 3, 1, 2);  prog[3] = rr(AND_, 4, 1, 2); prog[4] = rr(OR_, 5, 1, 2);
    prog[5] = rr(SLT, 6, 1, 2);  prog[6] = rr(SLT, 7, 2, 1);
    prog[7] = ri(ADDI, 0, 0, 16'd5); prog[8] = rr(ADD, 8, 0, 0); prog[9] = HLT; plen = 10;
    run_prog();
    rreg(3);
    n_cmp++; if (reg32 !== 32'hFFFF_FFED) begin n_bad++; $display("FAIL alu_sub: got %h want ffffffed", reg32); end
    rreg(4);
    n_cmp++; if (reg32 !== 32'd8) begin n_bad++; $display("FAIL alu_and: got %h want 8", reg32); end
    rreg(5);
    n_cmp++; if (reg32 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL alu_or: got %h want ffffffff", reg32); end
    rreg(6);
    n_cmp++; if (reg32 !== 32'd1) begin n_bad++; $display("FAIL alu_slt_neg: got %0d want 1", reg32); end
    rreg(7);
    n_cmp++; if (reg32 !== 32'd0) begin n_bad++; $display("FAIL alu_slt_pos: got %0d want 0", reg32); end
    rreg(8);
    n_cmp++; if (reg32 !== 32'd0) begin n_bad++; $display("FAIL r0_no_fwd: got %0d want 0", reg32); end
    n_cmp++; if (cyc != 14) begin n_bad++; $display("FAIL alu_cycles: got %0d want 14", cyc); end
  endtask

  task automatic test_factorial();
    prog[0] = ri(ADDI, 1, 0, 16'd5); prog[1] = ri(ADDI, 2, 0, 16'd1);
    prog[2] = ri(ADDI, 7, 0, 16'd3); prog[3] = rr(MUL, 2, 2, 1);
    prog[4] = ri(SUBI, 1, 1, 16'd1); prog[5] = ri(BNEQZ, 0, 1, 16'hFFFD);
    prog[6] = HLT; prog[7] = ri(ADDI, 7, 0, 16'd99); plen = 8;
    run_prog();
    rreg(2);
    n_cmp++; if (reg32 !== 32'd120) begin n_bad++; $display("FAIL fact_r2: got %0d want 120", reg32); end
    rreg(1);
    n_cmp++; if (reg32 !== 32'd0) begin n_bad++; $display("FAIL fact_r1: got %0d want 0", reg32); end
    rreg(7);
    n_cmp++; if (reg32 !== 32'd3) begin n_bad++; $display("FAIL fact_shadow_r7: got %0d want 3", reg32); end
    n_cmp++; if (ret32 !== 32'd19) begin n_bad++; $display("FAIL fact_retired: got %0d want 19", ret32); end
    n_cmp++; if (cyc != 31) begin n_bad++; $display("FAIL fact_cycles: got %0d want 31", cyc); end
  endtask

  task automatic test_branch_shadow();
    prog[0] = ri(ADDI, 5, 0, 16'd7); prog[1] = ri(ADDI, 6, 0, 16'd9);
    prog[2] = ri(BEQZ, 0, 0, 16'd2); prog[3] = HLT;
    prog[4] = ri(ADDI, 5, 0, 16'd1); prog[5] = ri(ADDI, 6, 0, 16'd2);
    prog[6] = HLT; plen = 7;
    run_prog();
    rreg(5);
    n_cmp++; if (reg32 !== 32'd7) begin n_bad++; $display("FAIL beqz_r5: got %0d want 7", reg32); end
    rreg(6);
    n_cmp++; if (reg32 !== 32'd2) begin n_bad++; $display("FAIL beqz_r6: got %0d want 2", reg32); end
    n_cmp++; if (ret32 !== 32'd5 || cyc != 11) begin n_bad++; $display("FAIL beqz_timing: got retired=%0d cyc=%0d want 5/11", ret32, cyc); end
  endtask

  task automatic test_illegal_op();
    prog[0] = ri(ADDI, 9, 0, 16'd4); prog[1] = 32'h4000_0000;
    prog[2] = ri(ADDI, 9, 0, 16'd8); plen = 3;
    run_prog();
    rreg(9);
    n_cmp++; if (reg32 !== 32'd4) begin n_bad++; $display("FAIL illegal_r9: got %0d want 4", reg32); end
    n_cmp++; if (ret32 !== 32'd2 || cyc != 6) begin n_bad++; $display("FAIL illegal_timing: got retired=%0d cyc=%0d want 2/6", ret32, cyc); end
  endtask

  task automatic test_xlen64();
    prog[0] = ri(ADDI, 1, 0, 16'hFFFF); prog[1] = ri(SLTI, 2, 1, 16'd0);
    prog[2] = rr(MUL, 3, 1, 1);         prog[3] = HLT; plen = 4;
    run_prog();
    rreg(1);
    n_cmp++; if (reg64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL x64_r1: got %h want all ones", reg64); end
    rreg(2);
    n_cmp++; if (reg64 !== 64'd1) begin n_bad++; $display("FAIL x64_r2: got %0d want 1", reg64); end
    rreg(3);
    n_cmp++; if (reg64 !== 64'd1) begin n_bad++; $display("FAIL x64_r3: got %0d want 1", reg64); end
    n_cmp++; if (reg32 !== 32'd1) begin n_bad++; $display("FAIL x32_r3: got %0d want 1", reg32); end
  endtask

  task automatic test_reset_mid();
    prog[0] = ri(ADDI, 1, 0, 16'd11); prog[1] = ri(SW, 1, 0, 16'd3); prog[2] = HLT; plen = 3;
    run_prog();
    rmem(3);
    n_cmp++; if (mem32 !== 32'd11) begin n_bad++; $display("FAIL rm_pre_mem3: got %0d want 11", mem32); end
    prog[0] = ri(ADDI, 1, 0, 16'd55);
    load_prog();
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1; #1;
    n_cmp++; if (halt32 !== 1'b0 || ret32 !== 32'd0) begin n_bad++; $display("FAIL rm_state: got halted=%b retired=%0d want 0/0", halt32, ret32); end
    repeat (3) @(posedge clk); #1;
    rmem(3);
    n_cmp++; if (mem32 !== 32'd11) begin n_bad++; $display("FAIL rm_no_store: got %0d want 11", mem32); end
    run_prog();
    rmem(3);
    n_cmp++; if (mem32 !== 32'd55) begin n_bad++; $display("FAIL rm_rerun_mem3: got %0d want 55", mem32); end
    n_cmp++; if (ret32 !== 32'd3 || cyc != 7) begin n_bad++; $display("FAIL rm_rerun_timing: got retired=%0d cyc=%0d want 3/7", ret32, cyc); end
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    dbg_reg_addr = '0; dbg_mem_addr = '0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_alu();
    test_factorial();
    test_branch_shadow();
    test_illegal_op();
    test_xlen64();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
